// File: rtl/spi_reg_pkg.sv
// Shared constants, FSM state encoding and command decode for the SPI register bridge.
package spi_reg_pkg;

  localparam logic [7:0] CMD_RAM_WR = 8'h10;
  localparam logic [7:0] CMD_RAM_RD = 8'h11;
  localparam logic [7:0] CMD_REG_WR = 8'h12;
  localparam logic [7:0] CMD_REG_RD = 8'h13;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WR_DATA,
    RD_PREFETCH,
    RD_DATA,
    IGNORE
  } state_t;

  // Phase that follows the address field for a given command byte.
  function automatic state_t state_after_addr(input logic [7:0] cmd_byte);
    case (cmd_byte)
      CMD_RAM_WR, CMD_REG_WR: return WR_DATA;
      CMD_RAM_RD, CMD_REG_RD: return RD_PREFETCH;
      default:                return IGNORE;
    endcase
  endfunction

  // RAM-targeted commands; the other valid ones address the register bank.
  function automatic logic cmd_is_ram(input logic [7:0] cmd_byte);
    return (cmd_byte == CMD_RAM_WR) || (cmd_byte == CMD_RAM_RD);
  endfunction

endpackage

// File: rtl/spi_reg_bridge_if.sv
// RAM-side bus of the SPI register bridge: address, write data, strobes, read data.
interface spi_reg_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output ram_addr, ram_wdata, ram_we, ram_re,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr, ram_wdata, ram_we, ram_re,
    output ram_rdata
  );
endinterface

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the clock domain and flags SCLK and CSN edges.
// Lead is the SCLK transition away from the idle level CPOL, trail the one back to it.
module spi_pin_sync #(
  parameter logic CPOL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic spi_sclk,
  input  logic spi_csn,
  input  logic spi_mosi,
  output logic sclk_lead,
  output logic sclk_trail,
  output logic csn_fall,
  output logic csn_sync,
  output logic mosi_sync
);
  logic [1:0] sclk_sr;
  logic [1:0] csn_sr;
  logic [1:0] mosi_sr;
  logic       sclk_d;
  logic       csn_d;

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_sr <= {2{CPOL}};
      sclk_d  <= CPOL;
      csn_sr  <= 2'b11;
      csn_d   <= 1'b1;
      mosi_sr <= 2'b00;
    end else begin
      sclk_sr <= {sclk_sr[0], spi_sclk};
      sclk_d  <= sclk_sr[1];
      csn_sr  <= {csn_sr[0], spi_csn};
      csn_d   <= csn_sr[1];
      mosi_sr <= {mosi_sr[0], spi_mosi};
    end
  end

  assign sclk_lead  = (sclk_d == CPOL) && (sclk_sr[1] != CPOL);
  assign sclk_trail = (sclk_d != CPOL) && (sclk_sr[1] == CPOL);
  assign csn_fall   = csn_d & ~csn_sr[1];
  assign csn_sync   = csn_sr[1];
  assign mosi_sync  = mosi_sr[1];

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI slave (CPHA=0) bridging an MCU to block RAM and a bank of control registers.
// Frame: 8-bit command, ADDR_W address bits, then any number of DATA_W-bit words,
// with the address auto-incrementing (modulo 2^ADDR_W) after every word.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | csn high, waiting for a csn falling edge
// CMD         | shifting in the 8-bit command
// ADDR        | shifting in the start address
// WR_DATA     | shifting in write words; each full word is committed
// RD_PREFETCH | fetching the next read word (strobe cycle, then load cycle)
// RD_DATA     | shifting the read word out on MISO
// IGNORE      | unknown command, sits quietly until csn high
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int   ADDR_W   = 8,
  parameter int   DATA_W   = 16,
  parameter int   NUM_REGS = 4,
  parameter logic CPOL     = 1'b0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         spi_sclk,
  input  logic                         spi_csn,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  output logic                         spi_miso_oe,
  spi_reg_bridge_if.master             ram,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [NUM_REGS-1:0]          reg_wr_strobe,
  output logic                         busy,
  output logic                         frame_err
);
  localparam int MAX_AD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int MAXN   = (MAX_AD > 8) ? MAX_AD : 8;
  localparam int CNT_W  = $clog2(MAXN);

  localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W - 1);

  logic sclk_lead, sclk_trail, csn_fall, csn_sync, mosi_sync;

  state_t            state, state_nxt;
  logic              err;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        cmd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wsr;
  logic [DATA_W-1:0] miso_sr;
  logic              pf_phase;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] reg_val;

  logic [ADDR_W-1:0] addr_shift;
  logic [ADDR_W-1:0] addr_inc;
  logic [DATA_W-1:0] word_shift;
  logic              last_bit;

  spi_pin_sync #(.CPOL(CPOL)) u_pin_sync (
    .clock      (clock),
    .reset      (reset),
    .spi_sclk   (spi_sclk),
    .spi_csn    (spi_csn),
    .spi_mosi   (spi_mosi),
    .sclk_lead  (sclk_lead),
    .sclk_trail (sclk_trail),
    .csn_fall   (csn_fall),
    .csn_sync   (csn_sync),
    .mosi_sync  (mosi_sync)
  );

  assign addr_shift = {addr[ADDR_W-2:0], mosi_sync};
  assign addr_inc   = addr + ADDR_W'(1);
  assign word_shift = {wsr[DATA_W-2:0], mosi_sync};
  assign last_bit   = sclk_lead && (cnt == '0);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and framing-error detection; csn high wins over any sclk edge.
  always_comb begin
    state_nxt = state;
    err       = 1'b0;
    case (state)
      IDLE: if (csn_fall) state_nxt = CMD;
      CMD: begin
        if (csn_sync) begin
          state_nxt = IDLE;
          err       = 1'b1;
        end else if (last_bit) begin
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (csn_sync) begin
          state_nxt = IDLE;
          err       = 1'b1;
        end else if (last_bit) begin
          state_nxt = state_after_addr(cmd);
        end
      end
      WR_DATA: begin
        if (csn_sync) begin
          state_nxt = IDLE;
          err       = (cnt != CNT_DATA);
        end
      end
      RD_PREFETCH: begin
        if (csn_sync)      state_nxt = IDLE;
        else if (pf_phase) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        if (csn_sync)      state_nxt = IDLE;
        else if (last_bit) state_nxt = RD_PREFETCH;
      end
      IGNORE: if (csn_sync) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Register readback mux; addresses beyond the bank read as zero.
  always_comb begin
    reg_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (addr == ADDR_W'(i)) reg_val = regs[i];
  end

  // Datapath: bit counter, shift registers, address, RAM strobes and register bank.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      cmd           <= '0;
      addr          <= '0;
      wsr           <= '0;
      miso_sr       <= '0;
      pf_phase      <= 1'b0;
      ram.ram_addr  <= '0;
      ram.ram_wdata <= '0;
      ram.ram_we    <= 1'b0;
      ram.ram_re    <= 1'b0;
      reg_wr_strobe <= '0;
      frame_err     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      ram.ram_we    <= 1'b0;
      ram.ram_re    <= 1'b0;
      reg_wr_strobe <= '0;
      frame_err     <= err;
      if (!csn_sync) begin
        case (state)
          IDLE: if (csn_fall) cnt <= CNT_CMD;
          CMD: begin
            if (sclk_lead) begin
              cmd <= {cmd[6:0], mosi_sync};
              cnt <= (cnt == '0) ? CNT_ADDR : cnt - CNT_W'(1);
            end
          end
          ADDR: begin
            if (sclk_lead) begin
              addr <= addr_shift;
              if (cnt == '0) begin
                cnt      <= CNT_DATA;
                pf_phase <= 1'b0;
                if (state_nxt == RD_PREFETCH && cmd_is_ram(cmd)) begin
                  ram.ram_re   <= 1'b1;
                  ram.ram_addr <= addr_shift;
                end
              end else begin
                cnt <= cnt - CNT_W'(1);
              end
            end
          end
          WR_DATA: begin
            if (sclk_lead) begin
              wsr <= word_shift;
              if (cnt == '0) begin
                cnt  <= CNT_DATA;
                addr <= addr_inc;
                if (cmd_is_ram(cmd)) begin
                  ram.ram_we    <= 1'b1;
                  ram.ram_addr  <= addr;
                  ram.ram_wdata <= word_shift;
                end else begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                    if (addr == ADDR_W'(i)) begin
                      regs[i]          <= word_shift;
                      reg_wr_strobe[i] <= 1'b1;
                    end
                  end
                end
              end else begin
                cnt <= cnt - CNT_W'(1);
              end
            end
          end
          RD_PREFETCH: begin
            // ram_rdata is valid the cycle after the strobe.
            if (!pf_phase) pf_phase <= 1'b1;
            else           miso_sr  <= cmd_is_ram(cmd) ? ram.ram_rdata : reg_val;
          end
          RD_DATA: begin
            if (sclk_lead) begin
              if (cnt == '0) begin
                cnt      <= CNT_DATA;
                addr     <= addr_inc;
                pf_phase <= 1'b0;
                if (cmd_is_ram(cmd)) begin
                  ram.ram_re   <= 1'b1;
                  ram.ram_addr <= addr_inc;
                end
              end else begin
                cnt <= cnt - CNT_W'(1);
              end
            end else if (sclk_trail && cnt != CNT_DATA) begin
              // The trail right after a load must keep the fresh MSB on MISO.
              miso_sr <= {miso_sr[DATA_W-2:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs_out[g*DATA_W +: DATA_W] = regs[g];
  end

  assign spi_miso_oe = (state == RD_PREFETCH) || (state == RD_DATA);
  assign spi_miso    = spi_miso_oe & miso_sr[DATA_W-1];
  assign busy        = ~csn_sync;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: one CPOL=0 and one CPOL=1 instance with RAM models.
module tb_spi_reg_bridge;
  localparam int HALF = 50;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic sclk_a = 1'b0, csn_a = 1'b1;
  logic sclk_b = 1'b1, csn_b = 1'b1;
  logic mosi = 1'b0;
  logic miso_a, oe_a, miso_b, oe_b;
  logic [63:0] regs_a, regs_b;
  logic [3:0]  strb_a, strb_b;
  logic busy_a, busy_b, ferr_a, ferr_b;

  spi_reg_bridge_if #(.ADDR_W(8), .DATA_W(16)) ram_a ();
  spi_reg_bridge_if #(.ADDR_W(8), .DATA_W(16)) ram_b ();

  spi_reg_bridge #(.ADDR_W(8), .DATA_W(16), .NUM_REGS(4), .CPOL(1'b0)) dut_a (
    .clock(clock), .reset(reset), .spi_sclk(sclk_a), .spi_csn(csn_a), .spi_mosi(mosi),
    .spi_miso(miso_a), .spi_miso_oe(oe_a), .ram(ram_a), .regs_out(regs_a),
    .reg_wr_strobe(strb_a), .busy(busy_a), .frame_err(ferr_a));

  spi_reg_bridge #(.ADDR_W(8), .DATA_W(16), .NUM_REGS(4), .CPOL(1'b1)) dut_b (
    .clock(clock), .reset(reset), .spi_sclk(sclk_b), .spi_csn(csn_b), .spi_mosi(mosi),
    .spi_miso(miso_b), .spi_miso_oe(oe_b), .ram(ram_b), .regs_out(regs_b),
    .reg_wr_strobe(strb_b), .busy(busy_b), .frame_err(ferr_b));

  // RAM models with a side port for preloading.
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else begin
      if (pre_we)       mem_a[pre_addr] <= pre_data;
      if (ram_a.ram_we) mem_a[ram_a.ram_addr] <= ram_a.ram_wdata;
      if (ram_b.ram_we) mem_b[ram_b.ram_addr] <= ram_b.ram_wdata;
    end
    if (ram_a.ram_re) ram_a.ram_rdata <= mem_a[ram_a.ram_addr];
    if (ram_b.ram_re) ram_b.ram_rdata <= mem_b[ram_b.ram_addr];
  end

  // Event monitors, sampled mid-cycle.
  int we_a = 0, re_a = 0, fe_a = 0, re_b = 0, fe_b = 0;
  logic [23:0] wlog_a[$];
  logic [23:0] wlog_b[$];
  logic [3:0]  slog_a[$];

  always @(negedge clock) begin
    if (ram_a.ram_we) begin
      we_a++;
      wlog_a.push_back({ram_a.ram_addr, ram_a.ram_wdata});
    end
    if (ram_b.ram_we) wlog_b.push_back({ram_b.ram_addr, ram_b.ram_wdata});
    if (ram_a.ram_re) re_a++;
    if (ram_b.ram_re) re_b++;
    if (ferr_a) fe_a++;
    if (ferr_b) fe_b++;
    if (strb_a != 4'b0) slog_a.push_back(strb_a);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  logic sel = 1'b0;  // 0 drives dut_a (CPOL=0), 1 drives dut_b (CPOL=1)

  task automatic set_sclk(input logic lead);
    if (sel) sclk_b = ~lead;
    else     sclk_a = lead;
  endtask

  task automatic cs_low();
    if (sel) csn_b = 1'b0;
    else     csn_a = 1'b0;
    #(2*HALF);
  endtask

  task automatic cs_high();
    #(HALF);
    if (sel) csn_b = 1'b1;
    else     csn_a = 1'b1;
    #(4*HALF);
  endtask

  // Shift n bits MSB first; MISO and its enable are sampled on each leading edge.
  task automatic send(input logic [31:0] v, input int n, output logic [31:0] r, output logic oe_any);
    r = '0;
    oe_any = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      #(HALF);
      set_sclk(1'b1);
      r = {r[30:0], (sel ? miso_b : miso_a)};
      oe_any = oe_any | (sel ? oe_b : oe_a);
      #(HALF);
      set_sclk(1'b0);
    end
  endtask

  task automatic wrap_frame();
    logic [31:0] r;
    logic o;
    cs_low();
    send(32'h10, 8, r, o);
    send(32'hFE, 8, r, o);
    send(32'h1234, 16, r, o);
    send(32'hABCD, 16, r, o);
    send(32'h5555, 16, r, o);
    cs_high();
  endtask

  logic [31:0] rd;
  logic oe_any;
  int snap_we, snap_re, snap_fe;

  initial begin
    #100;
    reset = 1'b0;
    #100;
    check_val("rst_regs_lo", regs_a[31:0], 32'h0);
    check_val("rst_regs_hi", regs_a[63:32], 32'h0);
    check_val("rst_busy", {31'b0, busy_a}, 32'h0);
    check_val("rst_oe", {31'b0, oe_a}, 32'h0);
    check_val("rst_we", {31'b0, ram_a.ram_we}, 32'h0);

    // RAM write burst with address wrap.
    sel = 1'b0;
    wlog_a.delete();
    cs_low();
    check_val("busy_in_frame", {31'b0, busy_a}, 32'h1);
    send(32'h10, 8, rd, oe_any);
    send(32'hFE, 8, rd, oe_any);
    send(32'h1234, 16, rd, oe_any);
    send(32'hABCD, 16, rd, oe_any);
    send(32'h5555, 16, rd, oe_any);
    cs_high();
    check_val("wr_count", wlog_a.size(), 32'd3);
    check_val("wr0", {8'h0, wlog_a[0]}, 32'h00FE1234);
    check_val("wr1", {8'h0, wlog_a[1]}, 32'h00FFABCD);
    check_val("wr2", {8'h0, wlog_a[2]}, 32'h00005555);
    check_val("wr_ferr", fe_a, 32'd0);

    // RAM read burst from preloaded words.
    pre_we = 1'b1; pre_addr = 8'h20; pre_data = 16'hBEEF; #10;
    pre_addr = 8'h21; pre_data = 16'h0F0F; #10;
    pre_we = 1'b0; #20;
    snap_re = re_a;
    cs_low();
    send(32'h11, 8, rd, oe_any);
    check_val("rd_oe_cmd", {31'b0, oe_any}, 32'h0);
    send(32'h20, 8, rd, oe_any);
    check_val("rd_oe_addr", {31'b0, oe_any}, 32'h0);
    send(32'h0, 16, rd, oe_any);
    check_val("rd_word0", rd, 32'hBEEF);
    check_val("rd_oe_data", {31'b0, oe_any}, 32'h1);
    send(32'h0, 16, rd, oe_any);
    check_val("rd_word1", rd, 32'h0F0F);
    cs_high();
    check_val("rd_re_count", re_a - snap_re, 32'd3);
    check_val("rd_oe_after", {31'b0, oe_a}, 32'h0);
    check_val("rd_ferr", fe_a, 32'd0);

    // Register write burst running past the bank.
    slog_a.delete();
    cs_low();
    send(32'h12, 8, rd, oe_any);
    send(32'h02, 8, rd, oe_any);
    send(32'h00FF, 16, rd, oe_any);
    send(32'h0100, 16, rd, oe_any);
    send(32'hAAAA, 16, rd, oe_any);
    cs_high();
    check_val("reg0_1", regs_a[31:0], 32'h0);
    check_val("reg2", {16'h0, regs_a[47:32]}, 32'h00FF);
    check_val("reg3", {16'h0, regs_a[63:48]}, 32'h0100);
    check_val("strb_count", slog_a.size(), 32'd2);
    check_val("strb0", {28'h0, slog_a[0]}, 32'h4);
    check_val("strb1", {28'h0, slog_a[1]}, 32'h8);

    // Register read burst at the top of the bank.
    cs_low();
    send(32'h13, 8, rd, oe_any);
    send(32'h03, 8, rd, oe_any);
    send(32'h0, 16, rd, oe_any);
    check_val("rreg3", rd, 32'h0100);
    send(32'h0, 16, rd, oe_any);
    check_val("rreg4", rd, 32'h0000);
    cs_high();

    // Unknown command is ignored.
    snap_we = we_a; snap_re = re_a; snap_fe = fe_a;
    cs_low();
    send(32'h55, 8, rd, oe_any);
    send(32'h00FFFF, 16, rd, oe_any);
    check_val("unk_oe", {31'b0, oe_any}, 32'h0);
    cs_high();
    check_val("unk_we", we_a - snap_we, 32'd0);
    check_val("unk_re", re_a - snap_re, 32'd0);
    check_val("unk_ferr", fe_a - snap_fe, 32'd0);

    // Write frame aborted after 9 data bits.
    snap_we = we_a; snap_fe = fe_a;
    cs_low();
    send(32'h10, 8, rd, oe_any);
    send(32'h40, 8, rd, oe_any);
    send(32'h1FF, 9, rd, oe_any);
    cs_high();
    check_val("abort_ferr", fe_a - snap_fe, 32'd1);
    check_val("abort_we", we_a - snap_we, 32'd0);

    // CPOL=1 instance, same write/wrap frame.
    sel = 1'b1;
    wlog_b.delete();
    wrap_frame();
    check_val("c1_wr_count", wlog_b.size(), 32'd3);
    check_val("c1_wr0", {8'h0, wlog_b[0]}, 32'h00FE1234);
    check_val("c1_wr1", {8'h0, wlog_b[1]}, 32'h00FFABCD);
    check_val("c1_wr2", {8'h0, wlog_b[2]}, 32'h00005555);
    check_val("c1_ferr", fe_b, 32'd0);

    // Reset during data bit 5 of a register write.
    sel = 1'b0;
    cs_low();
    send(32'h12, 8, rd, oe_any);
    send(32'h01, 8, rd, oe_any);
    send(32'hF, 4, rd, oe_any);
    mosi = 1'b1;
    #(HALF);
    sclk_a = 1'b1;
    #20;
    reset = 1'b1;
    #20;
    check_val("mid_rst_regs", regs_a[63:32], 32'h0);
    check_val("mid_rst_busy", {31'b0, busy_a}, 32'h0);
    sclk_a = 1'b0;
    csn_a = 1'b1;
    #40;
    reset = 1'b0;
    #100;
    check_val("post_rst_oe", {31'b0, oe_a}, 32'h0);
    snap_fe = fe_a;
    slog_a.delete();
    cs_low();
    send(32'h12, 8, rd, oe_any);
    send(32'h01, 8, rd, oe_any);
    send(32'h5A5A, 16, rd, oe_any);
    cs_high();
    check_val("post_rst_reg1", regs_a[31:0], 32'h5A5A0000);
    check_val("post_rst_hi", regs_a[63:32], 32'h0);
    check_val("post_rst_strb", {28'h0, slog_a[0]}, 32'h2);
    check_val("post_rst_nstrb", slog_a.size(), 32'd1);
    check_val("post_rst_ferr", fe_a - snap_fe, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
